cache_valid_array: RTL and testbench



---
 rtl/cache_valid_array_pkg.sv | 19 +
 rtl/cache_valid_sweep_ctr.sv | 84 ++++++++
 rtl/cache_valid_array.sv | 78 +++++++
 tb/tb_cache_valid_array.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_valid_array_pkg.sv
// Shared types and elaboration helpers for the cache valid-bit array.
package cache_valid_array_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_e;

  // Index width needed to address numlines sets.
  function automatic int setlen_of(input int numlines);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < numlines) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/cache_valid_sweep_ctr.sv
// Whole-cache invalidate sequencer: walks every set once and reports busy/done.
// CACHE_FLASH_INVALIDATE_EN replaces the walk with a single-cycle done pulse.
module cache_valid_sweep_ctr
  import cache_valid_array_pkg::*;
#(
  parameter int NUMLINES = 128,
  parameter int SETLEN   = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              invalidate,
  output logic              sweeping,
  output logic [SETLEN-1:0] sweep_set,
  output logic              busy,
  output logic              done
);

`ifdef CACHE_FLASH_INVALIDATE_EN

  logic done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) done_q <= 1'b0;
    else        done_q <= invalidate;
  end

  assign sweeping  = 1'b0;
  assign sweep_set = '0;
  assign busy      = 1'b0;
  assign done      = done_q;

`else

  localparam logic [SETLEN-1:0] LAST_SET = SETLEN'(NUMLINES - 1);

  sweep_state_e      state_q, state_d;
  logic [SETLEN-1:0] count_q, count_d;
  logic              done_q, done_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  // A fresh invalidate during a sweep restarts it from set 0.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (invalidate) begin
          state_d = SWEEP;
          count_d = '0;
        end
      end
      SWEEP: begin
        count_d = count_q + 1'b1;
        if (invalidate) begin
          count_d = '0;
        end else if (count_q == LAST_SET) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sweeping  = (state_q == SWEEP);
  assign sweep_set = count_q;
  assign busy      = (state_q == SWEEP);
  assign done      = done_q;

`endif

endmodule

// File: rtl/cache_valid_array.sv
// Per-set, per-way valid bits with registered, write-first read and whole-cache invalidate.
// CACHE_FLASH_INVALIDATE_EN selects single-cycle flash invalidate instead of the sweep.
module cache_valid_array
  import cache_valid_array_pkg::*;
#(
  parameter int NUMWAYS  = 4,
  parameter int NUMLINES = 128,
  parameter int SETLEN   = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               CacheEn,
  input  logic               FlushStage,
  input  logic [SETLEN-1:0]  CacheSetRead,
  input  logic [SETLEN-1:0]  CacheSetWrite,
  input  logic [NUMWAYS-1:0] WriteWay,
  input  logic               SetValid,
  input  logic               ClearValid,
  input  logic               InvalidateCache,
  output logic [NUMWAYS-1:0] ValidWay,
  output logic               InvalidateBusy,
  output logic               InvalidateDone
);

  if (SETLEN != setlen_of(NUMLINES)) begin : g_bad_setlen
    $error("cache_valid_array: SETLEN must equal log2(NUMLINES)");
  end

  logic [NUMWAYS-1:0] valid_bits [NUMLINES];
  logic               sweeping;
  logic [SETLEN-1:0]  sweep_set;
  logic               block_update;
  logic               write_en;
  logic [NUMWAYS-1:0] cur_row, write_row, read_row;

  cache_valid_sweep_ctr #(
    .NUMLINES(NUMLINES),
    .SETLEN  (SETLEN)
  ) u_sweep (
    .clk       (clk),
    .reset     (reset),
    .invalidate(InvalidateCache),
    .sweeping  (sweeping),
    .sweep_set (sweep_set),
    .busy      (InvalidateBusy),
    .done      (InvalidateDone)
  );

  // Any invalidate activity drops writes and forces the read port to zero.
  assign block_update = sweeping | InvalidateCache;
  assign write_en     = ~block_update & (ClearValid | (SetValid & ~FlushStage));
  assign cur_row      = valid_bits[CacheSetWrite];
  assign write_row    = ClearValid ? (cur_row & ~WriteWay) : (cur_row | WriteWay);
  assign read_row     = (write_en && (CacheSetRead == CacheSetWrite)) ? write_row
                                                                      : valid_bits[CacheSetRead];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUMLINES; i++) valid_bits[i] <= '0;
`ifdef CACHE_FLASH_INVALIDATE_EN
    end else if (InvalidateCache) begin
      for (int i = 0; i < NUMLINES; i++) valid_bits[i] <= '0;
`else
    end else if (sweeping) begin
      valid_bits[sweep_set] <= '0;
`endif
    end else if (write_en) begin
      valid_bits[CacheSetWrite] <= write_row;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            ValidWay <= '0;
    else if (block_update) ValidWay <= '0;
    else if (CacheEn)      ValidWay <= read_row;
  end

endmodule

// File: tb/tb_cache_valid_array.sv
// Self-checking bench for cache_valid_array: behavioural model plus directed literal checks.
// Follows CACHE_FLASH_INVALIDATE_EN to select flash or sweep expectations.
module tb_cache_valid_array;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       CacheEn = 1'b0;
  logic       FlushStage = 1'b0;
  logic [6:0] CacheSetRead = '0;
  logic [6:0] CacheSetWrite = '0;
  logic [3:0] WriteWay = '0;
  logic       SetValid = 1'b0;
  logic       ClearValid = 1'b0;
  logic       InvalidateCache = 1'b0;
  logic [3:0] ValidWay;
  logic       InvalidateBusy;
  logic       InvalidateDone;

  int checks = 0;
  int errors = 0;

  // Model state: stored bits, expected outputs, and remaining sets of an active sweep.
  bit [3:0] mdlMem [128];
  bit [3:0] mdlValidWay = '0;
  bit       mdlDone = 1'b0;
  int       sweepLeft = 0;
  int       sweepPos = 0;

  cache_valid_array #(
    .NUMWAYS (4),
    .NUMLINES(128),
    .SETLEN  (7)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .CacheEn        (CacheEn),
    .FlushStage     (FlushStage),
    .CacheSetRead   (CacheSetRead),
    .CacheSetWrite  (CacheSetWrite),
    .WriteWay       (WriteWay),
    .SetValid       (SetValid),
    .ClearValid     (ClearValid),
    .InvalidateCache(InvalidateCache),
    .ValidWay       (ValidWay),
    .InvalidateBusy (InvalidateBusy),
    .InvalidateDone (InvalidateDone)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model advances on each edge using the rules for reads, writes and invalidation.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 128; i++) mdlMem[i] = '0;
      mdlValidWay = '0;
      mdlDone     = 1'b0;
      sweepLeft   = 0;
      sweepPos    = 0;
    end else begin
      mdlDone = 1'b0;
`ifdef CACHE_FLASH_INVALIDATE_EN
      if (InvalidateCache) begin
        for (int i = 0; i < 128; i++) mdlMem[i] = '0;
        mdlValidWay = '0;
        mdlDone     = 1'b1;
      end else begin
`else
      if (sweepLeft > 0) begin
        mdlMem[sweepPos] = '0;
        mdlValidWay      = '0;
        if (InvalidateCache) begin
          sweepPos  = 0;
          sweepLeft = 128;
        end else begin
          sweepPos++;
          sweepLeft--;
          if (sweepLeft == 0) mdlDone = 1'b1;
        end
      end else if (InvalidateCache) begin
        sweepPos    = 0;
        sweepLeft   = 128;
        mdlValidWay = '0;
      end else begin
`endif
        if (ClearValid)                   mdlMem[CacheSetWrite] = mdlMem[CacheSetWrite] & ~WriteWay;
        else if (SetValid && !FlushStage) mdlMem[CacheSetWrite] = mdlMem[CacheSetWrite] | WriteWay;
        if (CacheEn) mdlValidWay = mdlMem[CacheSetRead];
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      checkOutput("cyc_validway", {28'd0, ValidWay}, {28'd0, mdlValidWay});
      checkOutput("cyc_busy", {31'd0, InvalidateBusy}, {31'd0, (sweepLeft > 0)});
      checkOutput("cyc_done", {31'd0, InvalidateDone}, {31'd0, mdlDone});
    end
  end

  // Drive one cycle of inputs, returning just after the following falling edge.
  task automatic applyStimulus(input logic en, input logic [6:0] rs, input logic [6:0] ws,
                               input logic [3:0] way, input logic sv, input logic cv,
                               input logic fl, input logic inv);
    CacheEn         = en;
    CacheSetRead    = rs;
    CacheSetWrite   = ws;
    WriteWay        = way;
    SetValid        = sv;
    ClearValid      = cv;
    FlushStage      = fl;
    InvalidateCache = inv;
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 7'd0, 7'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic readSet(input logic [6:0] s);
    applyStimulus(1'b1, s, 7'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic fillSet(input logic [6:0] s, input logic [3:0] way);
    applyStimulus(1'b0, 7'd0, s, way, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  int busyCycles;
  int donePulses;

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;
    checkOutput("reset_validway", {28'd0, ValidWay}, 32'h0);
    checkOutput("reset_busy", {31'd0, InvalidateBusy}, 32'h0);
    checkOutput("reset_done", {31'd0, InvalidateDone}, 32'h0);

    readSet(7'd0);   checkOutput("rd_set0", {28'd0, ValidWay}, 32'h0);
    readSet(7'd5);   checkOutput("rd_set5", {28'd0, ValidWay}, 32'h0);
    readSet(7'd127); checkOutput("rd_set127", {28'd0, ValidWay}, 32'h0);

    fillSet(7'd5, 4'b0100);
    readSet(7'd5);   checkOutput("set5_fill", {28'd0, ValidWay}, 32'h4);
    applyStimulus(1'b0, 7'd0, 7'd5, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0);
    readSet(7'd5);   checkOutput("set5_flushed", {28'd0, ValidWay}, 32'h4);

    applyStimulus(1'b1, 7'd9, 7'd9, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("set9_bypass", {28'd0, ValidWay}, 32'h2);
    applyStimulus(1'b1, 7'd9, 7'd9, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("set9_clear_wins", {28'd0, ValidWay}, 32'h2);
    applyStimulus(1'b0, 7'd9, 7'd9, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    readSet(7'd9);   checkOutput("set9_zero_way", {28'd0, ValidWay}, 32'h2);

`ifdef CACHE_FLASH_INVALIDATE_EN
    fillSet(7'd3, 4'b1111);
    readSet(7'd3);   checkOutput("set3_full", {28'd0, ValidWay}, 32'hf);
    applyStimulus(1'b1, 7'd3, 7'd3, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("flash_validway", {28'd0, ValidWay}, 32'h0);
    checkOutput("flash_done", {31'd0, InvalidateDone}, 32'h1);
    checkOutput("flash_busy", {31'd0, InvalidateBusy}, 32'h0);
    idleCycle();
    checkOutput("flash_done_drop", {31'd0, InvalidateDone}, 32'h0);
    readSet(7'd3);   checkOutput("flash_set3", {28'd0, ValidWay}, 32'h0);
`else
    fillSet(7'd0, 4'b1111);
    fillSet(7'd127, 4'b1111);
    readSet(7'd127); checkOutput("set127_full", {28'd0, ValidWay}, 32'hf);
    applyStimulus(1'b0, 7'd0, 7'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
    busyCycles = 0;
    donePulses = 0;
    while (InvalidateBusy && busyCycles < 400) begin
      busyCycles++;
      if (busyCycles == 50) applyStimulus(1'b0, 7'd0, 7'd127, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
      else                  idleCycle();
      if (InvalidateDone) donePulses++;
    end
    checkOutput("sweep_busy_len", busyCycles, 32'd128);
    idleCycle();
    if (InvalidateDone) donePulses++;
    checkOutput("sweep_done_once", donePulses, 32'd1);
    readSet(7'd0);   checkOutput("swept_set0", {28'd0, ValidWay}, 32'h0);
    readSet(7'd127); checkOutput("swept_set127", {28'd0, ValidWay}, 32'h0);

    applyStimulus(1'b0, 7'd0, 7'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
    busyCycles = 0;
    while (InvalidateBusy && busyCycles < 400) begin
      busyCycles++;
      if (busyCycles == 60) applyStimulus(1'b0, 7'd0, 7'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
      else                  idleCycle();
    end
    checkOutput("restart_busy_len", busyCycles, 32'd188);
    idleCycle();

    fillSet(7'd4, 4'b1010);
    applyStimulus(1'b0, 7'd0, 7'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (29) idleCycle();
    checkOutput("pre_reset_busy", {31'd0, InvalidateBusy}, 32'h1);
    #2 reset = 1'b0;
    #1;
    checkOutput("reset_mid_busy", {31'd0, InvalidateBusy}, 32'h0);
    checkOutput("reset_mid_done", {31'd0, InvalidateDone}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    donePulses = 0;
    for (int i = 0; i < 4; i++) begin
      idleCycle();
      if (InvalidateDone) donePulses++;
    end
    checkOutput("reset_no_done", donePulses, 32'd0);
    readSet(7'd4);   checkOutput("reset_cleared_set4", {28'd0, ValidWay}, 32'h0);
`endif

    idleCycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
